cluster_pwr_seq: RTL and testbench
==================================

Name: cluster_pwr_seq

Overview:
Cluster power/reset sequencer, directly downstream of the SoC control register block. It consumes the cluster_pow / cluster_byp / cluster_rstn / cluster_fetch_enable register outputs and converts them into an ordered, timed sequence toward the cluster domain: power switch request, clock enable, isolation release, reset release, fetch enable. Power-down runs the same sequence in reverse. It exposes busy, error and state status for readback.

Parameters:
SETTLE_CYCLES, 16, clock-settle cycles after clk_en change (>=1)
RST_CYCLES, 8, cycles reset is held after isolation release or before isolation set (>=1)
ACK_TIMEOUT, 1024, max cycles waiting for synchronised pwr_ack transition (>=1)
CNT_WIDTH, 16, counter width; must hold max(SETTLE_CYCLES, RST_CYCLES, ACK_TIMEOUT)-1

Ports:
HCLK  in  1  clock
HRESET  in  1  reset, synchronous, active-high
cluster_pow_i  in  1  power request from SoC control
cluster_byp_i  in  1  bypass; 1 forces the cluster-off target
cluster_rstn_i  in  1  software cluster reset (active-low), passed through only in ON
cluster_fetch_enable_i  in  1  software fetch enable, passed through only in ON
pwr_ack_i  in  1  power-switch acknowledge, asynchronous
pwr_req_o  out  1  power-switch enable
iso_en_o  out  1  isolation enable (1 = isolated)
clk_en_o  out  1  cluster clock gate enable
cluster_rstn_o  out  1  cluster reset, active-low
cluster_fetch_enable_o  out  1  cluster fetch enable
seq_busy_o  out  1  sequence in progress
seq_err_o  out  1  ack timeout occurred
seq_state_o  out  4  current state encoding

Behaviour:
- Target: req = cluster_pow_i & ~cluster_byp_i. It is sampled only in OFF and ON. Up and down sequences always run to completion before req is re-evaluated.
- pwr_ack_i passes through a 2-flop synchroniser (ack_s). Synchroniser flops reset to 0.
- All outputs are decoded from the state register only, plus the pass-through inputs in ON. There is no combinational path from pwr_ack_i.
- Counter: loaded with N-1 on state entry. The state exits in the cycle after the counter reads 0, so a timed state lasts exactly N cycles.
- States, with encoding, outputs (pwr_req, iso, clk, rstn, fetch), and transitions:
  - OFF (0), outputs 0,1,0,0,0: req=1 -> PWR_UP.
  - PWR_UP (1), outputs 1,1,0,0,0: ack_s=1 -> CLK_ON. ACK_TIMEOUT cycles without ack -> ERR.
  - CLK_ON (2), outputs 1,1,1,0,0: SETTLE_CYCLES -> ISO_REL.
  - ISO_REL (3), outputs 1,0,1,0,0: 1 cycle -> RST_REL.
  - RST_REL (4), outputs 1,0,1,0,0: RST_CYCLES -> ON.
  - ON (5), outputs 1,0,1,cluster_rstn_i,cluster_fetch_enable_i: req=0 -> DRAIN.
  - DRAIN (6), outputs 1,0,1,0,0: RST_CYCLES -> ISO_SET.
  - ISO_SET (7), outputs 1,1,1,0,0: 1 cycle -> CLK_OFF.
  - CLK_OFF (8), outputs 1,1,0,0,0: SETTLE_CYCLES -> PWR_DN.
  - PWR_DN (9), outputs 0,1,0,0,0: ack_s=0 -> OFF. ACK_TIMEOUT cycles -> ERR.
  - ERR (10), outputs 0,1,0,0,0: req=0 -> OFF.
- seq_busy_o = 1 in all states except OFF, ON and ERR.
- seq_err_o = 1 in ERR only. It clears on the transition to OFF.
- Reset values: state OFF, counter 0, outputs pwr_req 0, iso 1, clk 0, rstn 0, fetch 0, busy 0, err 0, seq_state 0.
- Latency: req rises in cycle t -> pwr_req_o=1 at t+1. With ack already high, the earliest CLK_ON is t+3 (synchroniser) and ON is entered at t+3+SETTLE_CYCLES+1+RST_CYCLES.
- Invariants, checked by assertion:
  - iso_en_o=0 implies clk_en_o=1 and pwr_req_o=1.
  - cluster_rstn_o=1 or cluster_fetch_enable_o=1 implies state ON.
  - clk_en_o=1 implies pwr_req_o=1.
- Reset mid-sequence: HRESET forces OFF outputs in the next cycle. There is no graceful power-down.
- Unused encodings 11-15 -> OFF, with safe outputs.

Decomposition:
- Package cluster_pwr_seq_pkg holds:
  - the state enum (4-bit, explicit values above);
  - the output-vector struct {pwr_req, iso, clk, rstn, fetch};
  - a per-state output constant.
- One sub-module, pwr_ack_sync: a 2-flop synchroniser with a synchronous active-high reset.

Test Plan:
- Power-up: pow=1, byp=0, ack raised 3 cycles after pwr_req (defaults) -> clk_en 1 cycle after ack_s, iso falls 16 cycles later, ON 9 cycles after that; rstn_o/fetch_o then follow inputs 1/1.
- Software reset in ON: cluster_rstn_i 1->0->1 -> cluster_rstn_o mirrors it combinationally; state stays 5, busy=0.
- Power-down via byp=1 in ON -> fetch/rstn drop next cycle, iso=1 after 8 cycles, clk_en=0 one cycle later, pwr_req=0 16 cycles later, OFF when ack_s falls.
- Ack timeout: ack held 0 after pow=1 -> ERR after 1024 cycles in PWR_UP, err=1, pwr_req=0; pow=0 -> OFF, err=0.
- Request toggles mid-sequence: pow pulses 1 for 2 cycles -> full up-sequence to ON, then immediate DRAIN and full down-sequence.
- HRESET asserted in RST_REL -> next cycle all outputs at reset values, state 0.

Source files
------------

// File: rtl/cluster_pwr_seq_pkg.sv
// Shared types for the cluster power/reset sequencer: state encoding,
// output-vector struct and the per-state output decode.
package cluster_pwr_seq_pkg;

    typedef enum logic [3:0] {
        ST_OFF     = 4'd0,
        ST_PWR_UP  = 4'd1,
        ST_CLK_ON  = 4'd2,
        ST_ISO_REL = 4'd3,
        ST_RST_REL = 4'd4,
        ST_ON      = 4'd5,
        ST_DRAIN   = 4'd6,
        ST_ISO_SET = 4'd7,
        ST_CLK_OFF = 4'd8,
        ST_PWR_DN  = 4'd9,
        ST_ERR     = 4'd10
    } state_e;

    typedef struct packed {
        logic pwr_req;
        logic iso;
        logic clk;
        logic rstn;
        logic fetch;
    } seq_out_t;

    localparam seq_out_t OUT_OFF     = '{pwr_req: 1'b0, iso: 1'b1, clk: 1'b0, rstn: 1'b0, fetch: 1'b0};
    localparam seq_out_t OUT_PWR     = '{pwr_req: 1'b1, iso: 1'b1, clk: 1'b0, rstn: 1'b0, fetch: 1'b0};
    localparam seq_out_t OUT_CLK_ISO = '{pwr_req: 1'b1, iso: 1'b1, clk: 1'b1, rstn: 1'b0, fetch: 1'b0};
    localparam seq_out_t OUT_RUN     = '{pwr_req: 1'b1, iso: 1'b0, clk: 1'b1, rstn: 1'b0, fetch: 1'b0};

    // ON returns the held-in-reset vector; the top overlays the software pass-through.
    function automatic seq_out_t state_out(input state_e s);
        case (s)
            ST_PWR_UP, ST_CLK_OFF:            state_out = OUT_PWR;
            ST_CLK_ON, ST_ISO_SET:            state_out = OUT_CLK_ISO;
            ST_ISO_REL, ST_RST_REL, ST_ON,
            ST_DRAIN:                         state_out = OUT_RUN;
            default:                          state_out = OUT_OFF;
        endcase
    endfunction

endpackage

// File: rtl/cluster_pwr_seq_ack_sync.sv
// Two-flop synchroniser for the asynchronous power-switch acknowledge.
module pwr_ack_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = d_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/cluster_pwr_seq.sv
// Cluster power/reset sequencer: orders power switch, clock, isolation,
// reset and fetch enable on the way up and reverses them on the way down.
module cluster_pwr_seq
    import cluster_pwr_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int RST_CYCLES    = 8,
    parameter int ACK_TIMEOUT   = 1024,
    parameter int CNT_WIDTH     = 16
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       cluster_pow_i,
    input  logic       cluster_byp_i,
    input  logic       cluster_rstn_i,
    input  logic       cluster_fetch_enable_i,
    input  logic       pwr_ack_i,
    output logic       pwr_req_o,
    output logic       iso_en_o,
    output logic       clk_en_o,
    output logic       cluster_rstn_o,
    output logic       cluster_fetch_enable_o,
    output logic       seq_busy_o,
    output logic       seq_err_o,
    output logic [3:0] seq_state_o
);

    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RST_LOAD    = CNT_WIDTH'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ACK_LOAD    = CNT_WIDTH'(ACK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ack_s;
    logic                 req;
    logic                 cnt_zero;
    seq_out_t             outs;

    pwr_ack_sync u_ack_sync (
        .clk (HCLK),
        .rst (HRESET),
        .d_i (pwr_ack_i),
        .q_o (ack_s)
    );

    assign req      = cluster_pow_i & ~cluster_byp_i;
    assign cnt_zero = (cnt_q == '0);

    // Timed states exit the cycle after the counter reads zero, so a load of N-1 gives N cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                if (req) begin
                    state_d = ST_PWR_UP;
                    cnt_d   = ACK_LOAD;
                end
            end
            ST_PWR_UP: begin
                if (ack_s) begin
                    state_d = ST_CLK_ON;
                    cnt_d   = SETTLE_LOAD;
                end else if (cnt_zero) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_CLK_ON: begin
                if (cnt_zero) begin
                    state_d = ST_ISO_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ISO_REL: begin
                state_d = ST_RST_REL;
                cnt_d   = RST_LOAD;
            end
            ST_RST_REL: begin
                if (cnt_zero) begin
                    state_d = ST_ON;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ON: begin
                if (!req) begin
                    state_d = ST_DRAIN;
                    cnt_d   = RST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cnt_zero) begin
                    state_d = ST_ISO_SET;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ISO_SET: begin
                state_d = ST_CLK_OFF;
                cnt_d   = SETTLE_LOAD;
            end
            ST_CLK_OFF: begin
                if (cnt_zero) begin
                    state_d = ST_PWR_DN;
                    cnt_d   = ACK_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_PWR_DN: begin
                if (!ack_s) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_zero) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ERR: begin
                if (!req) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        outs = state_out(state_q);
        if (state_q == ST_ON) begin
            outs.rstn  = cluster_rstn_i;
            outs.fetch = cluster_fetch_enable_i;
        end
    end

    assign pwr_req_o              = outs.pwr_req;
    assign iso_en_o               = outs.iso;
    assign clk_en_o               = outs.clk;
    assign cluster_rstn_o         = outs.rstn;
    assign cluster_fetch_enable_o = outs.fetch;
    assign seq_busy_o             = (state_q != ST_OFF) && (state_q != ST_ON) && (state_q != ST_ERR);
    assign seq_err_o              = (state_q == ST_ERR);
    assign seq_state_o            = state_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Directed bench for cluster_pwr_seq: walks up/down sequences, timeout,
// mid-sequence request drop and reset, with a queue of expected output vectors.
module tb_cluster_pwr_seq;

  localparam int S_OFF = 0, S_PWR_UP = 1, S_CLK_ON = 2, S_ISO_REL = 3, S_RST_REL = 4,
                 S_ON = 5, S_DRAIN = 6, S_ISO_SET = 7, S_CLK_OFF = 8, S_PWR_DN = 9, S_ERR = 10;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       cluster_pow_i, cluster_byp_i, cluster_rstn_i, cluster_fetch_enable_i, pwr_ack_i;
  logic       pwr_req_o, iso_en_o, clk_en_o, cluster_rstn_o, cluster_fetch_enable_o;
  logic       seq_busy_o, seq_err_o;
  logic [3:0] seq_state_o;

  int vectors = 0;
  int miscompares = 0;
  bit inv_en = 1'b0;
  logic [10:0] exp_q[$];

  cluster_pwr_seq dut (
    .HCLK                   (HCLK),
    .HRESET                 (HRESET),
    .cluster_pow_i          (cluster_pow_i),
    .cluster_byp_i          (cluster_byp_i),
    .cluster_rstn_i         (cluster_rstn_i),
    .cluster_fetch_enable_i (cluster_fetch_enable_i),
    .pwr_ack_i              (pwr_ack_i),
    .pwr_req_o              (pwr_req_o),
    .iso_en_o               (iso_en_o),
    .clk_en_o               (clk_en_o),
    .cluster_rstn_o         (cluster_rstn_o),
    .cluster_fetch_enable_o (cluster_fetch_enable_o),
    .seq_busy_o             (seq_busy_o),
    .seq_err_o              (seq_err_o),
    .seq_state_o            (seq_state_o)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // expected {pwr_req, iso, clk, rstn, fetch, busy, err, state[3:0]}
  function automatic logic [10:0] exp_vec(input int s, input logic rin, input logic fin);
    logic [4:0] o;
    logic busy, err;
    case (s)
      S_OFF:     o = 5'b01000;
      S_PWR_UP:  o = 5'b11000;
      S_CLK_ON:  o = 5'b11100;
      S_ISO_REL: o = 5'b10100;
      S_RST_REL: o = 5'b10100;
      S_ON:      o = {3'b101, rin, fin};
      S_DRAIN:   o = 5'b10100;
      S_ISO_SET: o = 5'b11100;
      S_CLK_OFF: o = 5'b11000;
      S_PWR_DN:  o = 5'b01000;
      default:   o = 5'b01000;
    endcase
    busy = !(s == S_OFF || s == S_ON || s == S_ERR);
    err  = (s == S_ERR);
    return {o, busy, err, 4'(s)};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {pwr_req_o, iso_en_o, clk_en_o, cluster_rstn_o, cluster_fetch_enable_o,
            seq_busy_o, seq_err_o, seq_state_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard
  task automatic sb_push(input int s, input logic rin, input logic fin);
    exp_q.push_back(exp_vec(s, rin, fin));
  endtask

  task automatic sb_check(input string tag);
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: observed empty queue required an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(obs_vec()), 32'(e));
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic go(input int s, input int max, input int exp_n, input string tag);
    int n;
    n = 0;
    sb_push(s, cluster_rstn_i, cluster_fetch_enable_i);
    do begin
      tick();
      n++;
    end while (seq_state_o !== 4'(s) && n < max);
    chk({tag, "_lat"}, 32'(n), 32'(exp_n));
    sb_check(tag);
  endtask

  always @(negedge HCLK) begin
    if (inv_en) begin
      chk("inv_iso", 32'(!iso_en_o && !(clk_en_o && pwr_req_o)), 32'd0);
      chk("inv_rstn_fetch", 32'((cluster_rstn_o || cluster_fetch_enable_o) && seq_state_o != 4'd5), 32'd0);
      chk("inv_clk", 32'(clk_en_o && !pwr_req_o), 32'd0);
    end
  end

  initial begin
    HRESET = 1'b1;
    cluster_pow_i = 1'b0;
    cluster_byp_i = 1'b0;
    cluster_rstn_i = 1'b1;
    cluster_fetch_enable_i = 1'b1;
    pwr_ack_i = 1'b0;
    tick();
    tick();
    sb_push(S_OFF, 1'b1, 1'b1);
    sb_check("reset_state");
    inv_en = 1'b1;
    HRESET = 1'b0;
    tick();
    tick();
    sb_push(S_OFF, 1'b1, 1'b1);
    sb_check("idle_off");

    // power-up, ack 3 cycles after pwr_req
    cluster_pow_i = 1'b1;
    go(S_PWR_UP, 5, 1, "up_pwr_req");
    repeat (3) tick();
    pwr_ack_i = 1'b1;
    go(S_CLK_ON, 10, 3, "up_clk_on");
    go(S_ISO_REL, 40, 16, "up_iso_rel");
    go(S_RST_REL, 5, 1, "up_rst_rel");
    go(S_ON, 20, 8, "up_on");

    // software reset pass-through in ON
    cluster_rstn_i = 1'b0;
    #1;
    sb_push(S_ON, 1'b0, 1'b1);
    sb_check("sw_rstn_low");
    tick();
    sb_push(S_ON, 1'b0, 1'b1);
    sb_check("sw_rstn_hold");
    cluster_rstn_i = 1'b1;
    #1;
    sb_push(S_ON, 1'b1, 1'b1);
    sb_check("sw_rstn_high");
    cluster_fetch_enable_i = 1'b0;
    #1;
    sb_push(S_ON, 1'b1, 1'b0);
    sb_check("sw_fetch_low");
    cluster_fetch_enable_i = 1'b1;

    // power-down through bypass
    tick();
    cluster_byp_i = 1'b1;
    go(S_DRAIN, 5, 1, "dn_drain");
    go(S_ISO_SET, 20, 8, "dn_iso_set");
    go(S_CLK_OFF, 5, 1, "dn_clk_off");
    go(S_PWR_DN, 40, 16, "dn_pwr_dn");
    pwr_ack_i = 1'b0;
    go(S_OFF, 10, 3, "dn_off");
    cluster_pow_i = 1'b0;
    cluster_byp_i = 1'b0;
    tick();

    // ack timeout
    cluster_pow_i = 1'b1;
    go(S_PWR_UP, 5, 1, "to_pwr_up");
    go(S_ERR, 1100, 1024, "to_err");
    tick();
    sb_push(S_ERR, 1'b1, 1'b1);
    sb_check("to_err_hold");
    cluster_pow_i = 1'b0;
    go(S_OFF, 5, 1, "to_off");

    // request pulse of 2 cycles: full up, then full down
    cluster_pow_i = 1'b1;
    pwr_ack_i = 1'b1;
    go(S_PWR_UP, 5, 1, "pulse_pwr_up");
    tick();
    cluster_pow_i = 1'b0;
    go(S_CLK_ON, 10, 1, "pulse_clk_on");
    go(S_ISO_REL, 40, 16, "pulse_iso_rel");
    go(S_RST_REL, 5, 1, "pulse_rst_rel");
    go(S_ON, 20, 8, "pulse_on");
    go(S_DRAIN, 5, 1, "pulse_drain");
    go(S_ISO_SET, 20, 8, "pulse_iso_set");
    go(S_CLK_OFF, 5, 1, "pulse_clk_off");
    go(S_PWR_DN, 40, 16, "pulse_pwr_dn");
    pwr_ack_i = 1'b0;
    go(S_OFF, 10, 3, "pulse_off");
    tick();

    // HRESET during RST_REL
    cluster_pow_i = 1'b1;
    pwr_ack_i = 1'b1;
    go(S_PWR_UP, 5, 1, "rst_pwr_up");
    go(S_CLK_ON, 10, 2, "rst_clk_on");
    go(S_ISO_REL, 40, 16, "rst_iso_rel");
    go(S_RST_REL, 5, 1, "rst_rst_rel");
    tick();
    tick();
    HRESET = 1'b1;
    tick();
    sb_push(S_OFF, 1'b0, 1'b0);
    sb_check("rst_mid_seq");
    cluster_pow_i = 1'b0;
    pwr_ack_i = 1'b0;
    tick();
    HRESET = 1'b0;
    repeat (3) tick();
    sb_push(S_OFF, 1'b0, 1'b0);
    sb_check("rst_stays_off");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    inv_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
